uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_os.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    localparam int unsigned OS_RATE = 16;
    localparam int unsigned OS_W    = 4;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Majority vote of the three mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every clk_div_i+1 clocks.
module uart_baud_tick #(
    parameter int unsigned DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIV_BITS-1:0] clk_div_i,
    output logic                tick_o
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;

    // Counter wraps at or above the divisor so a lowered divisor never stalls.
    always_comb begin
        cnt_d  = cnt_q + DIV_BITS'(1);
        tick_d = 1'b0;
        if (cnt_q >= clk_div_i) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority-vote sampling and a small receive FIFO.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_BITS   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_BITS-1:0]   clk_div,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  break_det,
    output logic                  busy
);

    localparam int unsigned BC_W   = $clog2(DATA_WIDTH);
    localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned WORD_W = DATA_WIDTH + 2;
    localparam logic [OS_W-1:0] OS_S7   = OS_W'(7);
    localparam logic [OS_W-1:0] OS_S8   = OS_W'(8);
    localparam logic [OS_W-1:0] OS_S9   = OS_W'(9);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

    logic tick;
    logic sync1_q, rx_s_q;

    rx_state_e             state_q, state_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  s7_q, s7_d, s8_q, s8_d;
    logic                  perr_q, perr_d, ferr_q, ferr_d, pbit_q, pbit_d;
    logic                  push_c, brk_c, maj_c, frame_bad_c;
    parity_mode_e          pmode_c;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              valid_q, valid_d, busy_q, busy_d;
    logic              ovr_q, ovr_d, brk_q;
    logic              full_c, pop_c, do_push_c;

    uart_baud_tick #(.DIV_BITS(DIV_BITS)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_div_i (clk_div),
        .tick_o    (tick)
    );

    // Two-flop synchroniser on the asynchronous serial line, idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    assign pmode_c     = parity_mode_e'(parity_mode);
    assign maj_c       = maj3(s7_q, s8_q, rx_s_q);
    assign frame_bad_c = ferr_q | ~maj_c;

    // Receiver next-state: advances only on oversample ticks, decisions at tick 9.
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        pbit_d     = pbit_q;
        push_c     = 1'b0;
        brk_c      = 1'b0;
        if (tick) begin
            if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH) begin
                os_cnt_d = os_cnt_q + OS_W'(1);
            end
            if (os_cnt_q == OS_S7) s7_d = rx_s_q;
            if (os_cnt_q == OS_S8) s8_d = rx_s_q;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d  = ST_START;
                        os_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (os_cnt_q == OS_S9 && maj_c) begin
                        state_d  = ST_IDLE;
                        os_cnt_d = '0;
                    end else if (os_cnt_q == OS_LAST) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                        pbit_d    = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (os_cnt_q == OS_S9) begin
                        shift_d = {maj_c, shift_q[DATA_WIDTH-1:1]};
                    end else if (os_cnt_q == OS_LAST) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            stop_cnt_d = 1'b0;
                            state_d    = (pmode_c == PAR_EVEN || pmode_c == PAR_ODD)
                                         ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (os_cnt_q == OS_S9) begin
                        pbit_d = maj_c;
                        perr_d = (^shift_q) ^ maj_c ^ (pmode_c == PAR_ODD);
                    end else if (os_cnt_q == OS_LAST) begin
                        state_d    = ST_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
                ST_STOP: begin
                    if (os_cnt_q == OS_S9) begin
                        ferr_d = frame_bad_c;
                        if (stop_cnt_q >= stop_bits) begin
                            os_cnt_d = '0;
                            if (frame_bad_c && shift_q == '0 && !pbit_q) begin
                                brk_c   = 1'b1;
                                state_d = ST_WAIT_HIGH;
                            end else begin
                                push_c  = 1'b1;
                                state_d = frame_bad_c ? ST_WAIT_HIGH : ST_IDLE;
                            end
                        end
                    end else if (os_cnt_q == OS_LAST) begin
                        stop_cnt_d = 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_d  = ST_IDLE;
                        os_cnt_d = '0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    os_cnt_d = '0;
                end
            endcase
        end
    end

    // FIFO pointer update; simultaneous push and pop always both succeed.
    always_comb begin
        full_c    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
        pop_c     = valid_q & rx_ready;
        do_push_c = push_c & (~full_c | pop_c);
        ovr_d     = push_c & full_c & ~pop_c;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        valid_d   = (wr_ptr_d != rd_ptr_d);
        busy_d    = (state_d != ST_IDLE);
    end

    // Receiver, FIFO and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            pbit_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            pbit_q     <= pbit_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_c;
            if (do_push_c) mem_q[wr_ptr_q[IDX_W-1:0]] <= {shift_q, perr_q, ferr_d};
        end
    end

    assign rx_data    = mem_q[rd_ptr_q[IDX_W-1:0]][WORD_W-1:2];
    assign parity_err = mem_q[rd_ptr_q[IDX_W-1:0]][1];
    assign frame_err  = mem_q[rd_ptr_q[IDX_W-1:0]][0];
    assign rx_valid   = valid_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: clk_div=3 gives 64 clocks per bit.
module tb_uart_rx_os;

    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] clk_div;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        rx_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        break_det;
    logic        busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;
    logic busy_seen = 1'b0;

    uart_rx_os #(.DATA_WIDTH(8), .DIV_BITS(16), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_div     (clk_div),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .break_det   (break_det),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (overrun)   ovr_cnt++;
        if (break_det) brk_cnt++;
        if (busy)      busy_seen = 1'b1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_clks(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pbit,
                              input logic stop0, input logic two, input logic stop1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(pbit);
        send_bit(stop0);
        if (two) send_bit(stop1);
    endtask

    task automatic pop;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_in       = 1'b1;
        rx_ready    = 1'b0;
        clk_div     = 16'd3;
        parity_mode = 2'b00;
        stop_bits   = 1'b0;
        wait_clks(5);
        check("reset_valid",   32'(rx_valid),  32'd0);
        check("reset_busy",    32'(busy),      32'd0);
        check("reset_overrun", 32'(overrun),   32'd0);
        check("reset_break",   32'(break_det), 32'd0);
        rst_n = 1'b1;
        wait_clks(20);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_clks(16);
        check("a5_valid", 32'(rx_valid),   32'd1);
        check("a5_data",  32'(rx_data),    32'hA5);
        check("a5_perr",  32'(parity_err), 32'd0);
        check("a5_ferr",  32'(frame_err),  32'd0);
        check("a5_busy",  32'(busy),       32'd0);
        pop();
        check("a5_popped", 32'(rx_valid), 32'd0);

        // Even parity, bad parity bit
        parity_mode = 2'b01;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_clks(16);
        check("even03_data", 32'(rx_data),    32'h03);
        check("even03_perr", 32'(parity_err), 32'd1);
        check("even03_ferr", 32'(frame_err),  32'd0);
        pop();
        // Even parity, good parity bit
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_clks(16);
        check("even07_data", 32'(rx_data),    32'h07);
        check("even07_perr", 32'(parity_err), 32'd0);
        pop();
        // Odd parity with total ones even -> error
        parity_mode = 2'b10;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_clks(16);
        check("odd07_perr", 32'(parity_err), 32'd1);
        pop();
        parity_mode = 2'b00;

        // Two stop bits: good, then bad second stop
        stop_bits = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_clks(16);
        check("2stop_data", 32'(rx_data),   32'h5A);
        check("2stop_ferr", 32'(frame_err), 32'd0);
        pop();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1);
        check("2stop_bad_data", 32'(rx_data),   32'hC3);
        check("2stop_bad_ferr", 32'(frame_err), 32'd1);
        pop();
        stop_bits = 1'b0;

        // 0x55 with low stop bit, then a 12-bit break
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_clks(16);
        check("f55_data",   32'(rx_data),   32'h55);
        check("f55_ferr",   32'(frame_err), 32'd1);
        check("f55_wait",   32'(busy),      32'd1);
        rx_in = 1'b1;
        wait_clks(BIT_CLK);
        check("f55_idle",   32'(busy),      32'd0);
        pop();
        brk_cnt = 0;
        rx_in = 1'b0;
        wait_clks(12 * BIT_CLK);
        check("brk_held_busy", 32'(busy), 32'd1);
        rx_in = 1'b1;
        wait_clks(2 * BIT_CLK);
        check("brk_pulses", 32'(brk_cnt),  32'd1);
        check("brk_nopush", 32'(rx_valid), 32'd0);
        check("brk_idle",   32'(busy),     32'd0);

        // Overrun on fifth frame into a 4-deep FIFO
        ovr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(8'h11 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 3) check("ovr_none_yet", 32'(ovr_cnt), 32'd0);
        end
        wait_clks(16);
        check("ovr_pulse", 32'(ovr_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(rx_valid), 32'd1);
            check("drain_data",  32'(rx_data),  32'(8'h11 + i));
            pop();
        end
        check("drain_empty", 32'(rx_valid), 32'd0);

        // Short low glitch on idle line
        busy_seen = 1'b0;
        rx_in = 1'b0;
        wait_clks(12);
        rx_in = 1'b1;
        wait_clks(80);
        check("glitch_seen",  32'(busy_seen), 32'd1);
        check("glitch_busy",  32'(busy),      32'd0);
        check("glitch_valid", 32'(rx_valid),  32'd0);

        // Reset in the middle of 0x3C data bits
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_in = 1'b1;
        wait_clks(32);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        wait_clks(3);
        check("rst_valid",   32'(rx_valid),  32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        check("rst_break",   32'(break_det), 32'd0);
        wait_clks(10);
        rst_n = 1'b1;
        wait_clks(2 * BIT_CLK);
        check("post_rst_busy",  32'(busy),     32'd0);
        check("post_rst_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_clks(16);
        check("f7e_valid", 32'(rx_valid),   32'd1);
        check("f7e_data",  32'(rx_data),    32'h7E);
        check("f7e_perr",  32'(parity_err), 32'd0);
        check("f7e_ferr",  32'(frame_err),  32'd0);
        pop();
        check("f7e_single", 32'(rx_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
